// File: rtl/img_win_seq.sv
// img_win_seq: sequencer for the 5x5/4x4 image window buffer on the EPU convolution path.
//
// Slides a stride-1 KxK window (K = 5 or 4) across an IMG_W x IMG_H 8-bit image.
// It issues image-memory reads and the matching one-cycle-late buffer load strobes,
// pulses the buffer shift before a 5x5 column refill, and handshakes each window
// with the convolution engine.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_start           start pulse, sampled only in IDLE (latches i_ksize, i_base)
//   i_abort           synchronous abort, back to IDLE next cycle, no o_done
//   i_ksize           0 = 5x5 kernel, 1 = 4x4 kernel
//   i_base            image base address
//   o_img_rd          image read enable (data valid one cycle later)
//   o_img_addr        read address, 0 when not reading
//   o_image_new_25    5x5 full-load strobe
//   o_image_new_5     5x5 column-refill strobe
//   o_image_new_16    4x4 load strobe
//   o_image_new_8     tied 0
//   o_shift           buffer shift pulse
//   o_win_valid       window ready, held until i_conv_done
//   i_conv_done       engine finished the current window
//   o_win_row/col     top-left coordinate of the current window
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse after the last window
//   o_stall_cnt       WAIT_CONV cycle count since last start
//
// Build option: define IMG_WIN_STALL_CNT_EN to build the saturating stall counter;
// otherwise o_stall_cnt is tied to 0.
module img_win_seq #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_ksize,
   input  logic [ADDR_W-1:0] i_base,
   output logic              o_img_rd,
   output logic [ADDR_W-1:0] o_img_addr,
   output logic              o_image_new_25,
   output logic              o_image_new_5,
   output logic              o_image_new_16,
   output logic              o_image_new_8,
   output logic              o_shift,
   output logic              o_win_valid,
   input  logic              i_conv_done,
   output logic [7:0]        o_win_row,
   output logic [7:0]        o_win_col,
   output logic              o_busy,
   output logic              o_done,
   output logic [15:0]       o_stall_cnt
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_FULL = 3'd1;
   localparam logic [2:0] S_SHIFT     = 3'd2;
   localparam logic [2:0] S_LOAD_COL  = 3'd3;
   localparam logic [2:0] S_DRAIN     = 3'd4;
   localparam logic [2:0] S_WAIT_CONV = 3'd5;
   localparam logic [2:0] S_FIN       = 3'd6;
   localparam logic [7:0] COL_LAST5 = 8'(IMG_W - 5);
   localparam logic [7:0] COL_LAST4 = 8'(IMG_W - 4);
   localparam logic [7:0] ROW_LAST5 = 8'(IMG_H - 5);
   localparam logic [7:0] ROW_LAST4 = 8'(IMG_H - 4);
   logic [2:0]        state, nxt;
   logic              ks;
   logic [ADDR_W-1:0] base;
   logic [2:0]        rr, cc, cc_eff, k_m1;
   logic [7:0]        win_row, win_col, col_last, row_last;
   logic              s25, s5, s16;
   logic              last_px, last_win, col_end, accept;
   assign k_m1     = ks ? 3'd3 : 3'd4;
   assign col_last = ks ? COL_LAST4 : COL_LAST5;
   assign row_last = ks ? ROW_LAST4 : ROW_LAST5;
   assign col_end  = win_col == col_last;
   assign last_win = col_end && win_row == row_last;
   // a refill only walks the rows of the new rightmost column
   assign last_px  = rr == k_m1 && (state == S_LOAD_COL || cc == k_m1);
   assign cc_eff   = state == S_LOAD_COL ? k_m1 : cc;
   assign accept   = state == S_IDLE && i_start && !i_abort;
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:      nxt = i_start ? S_LOAD_FULL : S_IDLE;
         S_LOAD_FULL: nxt = last_px ? S_DRAIN : S_LOAD_FULL;
         S_SHIFT:     nxt = S_LOAD_COL;
         S_LOAD_COL:  nxt = last_px ? S_DRAIN : S_LOAD_COL;
         S_DRAIN:     nxt = S_WAIT_CONV;
         S_WAIT_CONV: nxt = !i_conv_done ? S_WAIT_CONV : last_win ? S_FIN : (col_end || ks) ? S_LOAD_FULL : S_SHIFT;
         S_FIN:       nxt = S_IDLE;
         default:     nxt = S_IDLE;
      endcase
      if (i_abort) nxt = S_IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ks      <= 1'b0;
         base    <= '0;
         rr      <= 3'd0;
         cc      <= 3'd0;
         win_row <= 8'd0;
         win_col <= 8'd0;
         s25     <= 1'b0;
         s5      <= 1'b0;
         s16     <= 1'b0;
      end else begin
         state <= nxt;
         rr    <= (o_img_rd && rr != k_m1) ? rr + 3'd1 : 3'd0;
         cc    <= state == S_LOAD_FULL ? cc + {2'b00, rr == k_m1} : 3'd0;
         // strobes trail the reads by one cycle; an abort kills the pending one
         s25   <= !i_abort && state == S_LOAD_FULL && !ks;
         s16   <= !i_abort && state == S_LOAD_FULL && ks;
         s5    <= !i_abort && state == S_LOAD_COL;
         if (accept) begin
            ks      <= i_ksize;
            base    <= i_base;
            win_row <= 8'd0;
            win_col <= 8'd0;
         end
         if (state == S_WAIT_CONV && i_conv_done && !i_abort && !last_win) begin
            win_col <= col_end ? 8'd0 : win_col + 8'd1;
            win_row <= col_end ? win_row + 8'd1 : win_row;
         end
      end
   end
   assign o_img_rd       = state == S_LOAD_FULL || state == S_LOAD_COL;
   assign o_img_addr     = o_img_rd ? ADDR_W'(32'(base) + (32'(win_row) + 32'(rr)) * 32'(IMG_W) + 32'(win_col) + 32'(cc_eff)) : '0;
   assign o_image_new_25 = s25;
   assign o_image_new_5  = s5;
   assign o_image_new_16 = s16;
   assign o_image_new_8  = 1'b0;
   assign o_shift        = state == S_SHIFT;
   assign o_win_valid    = state == S_WAIT_CONV;
   assign o_win_row      = win_row;
   assign o_win_col      = win_col;
   assign o_busy         = state != S_IDLE;
   assign o_done         = state == S_FIN;
`ifdef IMG_WIN_STALL_CNT_EN
   logic [15:0] stall;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall <= 16'd0;
      else if (accept) stall <= 16'd0;
      else if (state == S_WAIT_CONV && stall != 16'hFFFF) stall <= stall + 16'd1;
   end
   assign o_stall_cnt = stall;
`else
   assign o_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_img_win_seq.sv
// tb_img_win_seq: directed bench for img_win_seq on a 6x6 image.
module tb_img_win_seq;
   localparam int W = 6, H = 6, AW = 10;
   logic clk = 0, rst = 0, i_start = 0, i_abort = 0, i_ksize = 0, i_conv_done = 0;
   logic [AW-1:0] i_base = '0;
   logic o_img_rd, o_image_new_25, o_image_new_5, o_image_new_16, o_image_new_8;
   logic o_shift, o_win_valid, o_busy, o_done;
   logic [AW-1:0] o_img_addr;
   logic [7:0] o_win_row, o_win_col;
   logic [15:0] o_stall_cnt;
   always #5 clk = ~clk;
   img_win_seq #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_ksize(i_ksize),
      .i_base(i_base), .o_img_rd(o_img_rd), .o_img_addr(o_img_addr),
      .o_image_new_25(o_image_new_25), .o_image_new_5(o_image_new_5),
      .o_image_new_16(o_image_new_16), .o_image_new_8(o_image_new_8),
      .o_shift(o_shift), .o_win_valid(o_win_valid), .i_conv_done(i_conv_done),
      .o_win_row(o_win_row), .o_win_col(o_win_col), .o_busy(o_busy),
      .o_done(o_done), .o_stall_cnt(o_stall_cnt)
   );
   int n_tot = 0, n_pass = 0, n_fail = 0, cyc = 0;
   int n25 = 0, n5 = 0, n16 = 0, n8 = 0, nsh = 0, ndone = 0, ovl = 0, tchg = 0;
   int aq[$], vq[$], rq[$], cq[$], shq[$], s5q[$];
   logic pv = 0;
   logic [2:0] pst = 0;
   int stall_exp;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic clear();
      n25 = 0; n5 = 0; n16 = 0; nsh = 0; ndone = 0; ovl = 0; tchg = 0;
      aq.delete(); vq.delete(); rq.delete(); cq.delete(); shq.delete(); s5q.delete();
   endtask
   task automatic tick();
      logic [2:0] st;
      @(posedge clk); #1; cyc++;
      st = {o_image_new_25, o_image_new_5, o_image_new_16};
      if (o_img_rd) aq.push_back(int'(o_img_addr));
      n25 += int'(o_image_new_25); n5 += int'(o_image_new_5); n16 += int'(o_image_new_16);
      n8 += int'(o_image_new_8); nsh += int'(o_shift); ndone += int'(o_done);
      if (o_shift && st != 0) ovl++;
      if (st != 0 && pst != 0 && st != pst) tchg++;
      if (o_win_valid && !pv) begin vq.push_back(cyc); rq.push_back(int'(o_win_row)); cq.push_back(int'(o_win_col)); end
      if (o_shift) shq.push_back(cyc);
      if (o_image_new_5) s5q.push_back(cyc);
      pv = o_win_valid; pst = st;
   endtask
   task automatic start(input logic ks);
      clear(); cyc = 0; i_ksize = ks; i_base = '0; i_start = 1;
      tick(); i_start = 0;
   endtask
   task automatic wait_valid();
      int g = 0;
      while (!o_win_valid && g < 200) begin tick(); g++; end
      chk("wait_valid", o_win_valid, 1);
   endtask
   task automatic run(input int dly);
      int g = 0;
      while (!o_done && g < 3000) begin
         if (o_win_valid) begin
            repeat (dly) tick();
            i_conv_done = 1; tick(); i_conv_done = 0;
         end else tick();
         g++;
      end
      chk("done_seen", o_done, 1);
   endtask
   initial begin
      #2 rst = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {o_busy, o_img_rd, o_image_new_25, o_image_new_5, o_image_new_16, o_image_new_8, o_shift, o_win_valid, o_done}, 0);
      chk("rst_pos", {o_win_row, o_win_col, o_stall_cnt}, 0);
      chk("rst_addr", o_img_addr, 0);
      rst = 0;
      tick();
      // 5x5 walk, engine answers 2 cycles after each window
      start(0);
      chk("c1_rd", o_img_rd, 1);
      chk("c1_addr", o_img_addr, 0);
      run(2);
      chk("a_nwin", vq.size(), 4);
      chk("a_valid", {vq[0][7:0], vq[1][7:0], vq[2][7:0], vq[3][7:0]}, {8'd27, 8'd37, 8'd66, 8'd76});
      chk("a_rows", {rq[0][3:0], rq[1][3:0], rq[2][3:0], rq[3][3:0]}, 16'h0011);
      chk("a_cols", {cq[0][3:0], cq[1][3:0], cq[2][3:0], cq[3][3:0]}, 16'h0101);
      chk("a_nrd", aq.size(), 60);
      chk("a_addr0_5", {aq[0][7:0], aq[1][7:0], aq[4][7:0], aq[5][7:0]}, {8'd0, 8'd6, 8'd24, 8'd1});
      chk("a_addr24", aq[24], 28);
      chk("a_refill", {aq[25][7:0], aq[26][7:0], aq[27][7:0], aq[28][7:0]}, {8'd5, 8'd11, 8'd17, 8'd23});
      chk("a_refill4", aq[29], 29);
      chk("a_rowload", aq[30], 6);
      chk("a_refill2", {aq[55][7:0], aq[59][7:0]}, {8'd11, 8'd35});
      chk("a_shift", {shq.size(), shq[0], shq[1]}, {32'd2, 32'd30, 32'd69});
      chk("a_new5_t", {s5q[0][7:0], s5q[4][7:0]}, {8'd32, 8'd36});
      chk("a_counts", {n25[7:0], n5[7:0], n16[7:0], nsh[7:0]}, {8'd50, 8'd10, 8'd0, 8'd2});
      chk("a_ovl_tchg", {ovl[15:0], tchg[15:0]}, 0);
      repeat (3) tick();
      chk("a_done_once", ndone, 1);
      chk("a_idle", o_busy, 0);
      // 4x4 walk
      start(1);
      run(2);
      chk("b_nwin", vq.size(), 9);
      chk("b_valid", {vq[0][7:0], vq[1][7:0], vq[2][7:0], vq[8][7:0]}, {8'd18, 8'd38, 8'd58, 8'd178});
      chk("b_pos", {rq[2][3:0], cq[2][3:0], rq[3][3:0], cq[3][3:0], rq[8][3:0], cq[8][3:0]}, 24'h021022);
      chk("b_counts", {n25[7:0], n5[7:0], n16[7:0], nsh[7:0]}, {8'd0, 8'd0, 8'd144, 8'd0});
      chk("b_nrd", aq.size(), 144);
      chk("b_addr", {aq[4][7:0], aq[16][7:0], aq[48][7:0], aq[128][7:0]}, {8'd1, 8'd1, 8'd6, 8'd14});
      chk("b_addr_last", aq[143], 35);
      chk("b_tchg", tchg, 0);
      tick();
      // abort inside the column refill
      start(0);
      wait_valid();
      tick(); tick();
      i_conv_done = 1; tick(); i_conv_done = 0;
      chk("c_shift", {cyc[7:0], 7'd0, o_shift}, {8'd30, 8'd1});
      tick(); tick();
      chk("c_in_col", {o_img_rd, o_img_addr}, {1'b1, 10'd11});
      i_abort = 1; tick(); i_abort = 0;
      chk("c_abort", {o_busy, o_img_rd, o_image_new_5, o_done, o_win_valid}, 0);
      clear();
      repeat (10) tick();
      chk("c_quiet", n25 + n5 + n16 + ndone + aq.size(), 0);
      // restart with stray start/conv_done during the load
      start(0);
      repeat (4) tick();
      i_start = 1; i_conv_done = 1; tick(); i_start = 0; i_conv_done = 0;
      wait_valid();
      chk("d_valid", vq[0], 27);
      chk("d_pos", {rq[0][7:0], cq[0][7:0]}, 0);
      chk("d_nrd", aq.size(), 25);
      chk("d_addr", {aq[0][7:0], aq[5][7:0], aq[24][7:0]}, {8'd0, 8'd1, 8'd28});
      i_start = 1; tick(); i_start = 0;
      chk("d_start_busy", {o_win_valid, o_win_row, o_win_col}, {1'b1, 16'd0});
      run(2);
      chk("d_nwin", vq.size(), 4);
      tick();
      // asynchronous reset mid-load
      start(0);
      repeat (5) tick();
      chk("e_loading", o_img_rd, 1);
      #2 rst = 1;
      #1;
      chk("e_rst_ctl", {o_busy, o_img_rd, o_image_new_25, o_shift, o_win_valid, o_done}, 0);
      chk("e_rst_addr", o_img_addr, 0);
      #2 rst = 0;
      @(posedge clk); #1;
      // stall count with engine holding 10 cycles per window
`ifdef IMG_WIN_STALL_CNT_EN
      stall_exp = 44;
`else
      stall_exp = 0;
`endif
      start(0);
      run(10);
      chk("f_stall", o_stall_cnt, stall_exp);
      chk("f_nwin", vq.size(), 4);
      repeat (3) tick();
      chk("f_stall_hold", o_stall_cnt, stall_exp);
      chk("new8_zero", n8, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
